// File: rtl/arb_pkg.sv
// Shared types and helpers for mem_arbiter: FSM state, timeout length, round-robin search.
package arb_pkg;

  localparam int unsigned MAX_REQ     = 16;
  localparam int unsigned IDX_MAX_W   = 4;
  localparam int unsigned TIMEOUT_CYC = 1024;
  localparam int unsigned TMO_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

  // First set bit of req searching from last+1 upward, wrapping at n; returns last if none set.
  function automatic logic [IDX_MAX_W-1:0] next_grant(input logic [MAX_REQ-1:0] req,
                                                      input logic [IDX_MAX_W-1:0] last,
                                                      input int unsigned n);
    logic [IDX_MAX_W-1:0] idx;
    int unsigned          cand;
    idx = last;
    // Walk offsets n..1 so the smallest offset is written last and wins.
    for (int unsigned k = 0; k < n; k++) begin
      cand = (32'(last) + n - k) % n;
      if (req[cand[IDX_MAX_W-1:0]]) idx = cand[IDX_MAX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-array and shared-memory signal bundle around mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);

  logic [NUM_REQ-1:0] req_ce_i;
  logic [NUM_REQ-1:0] req_we_i;
  logic [ADDR_W-1:0]  req_addr_i  [NUM_REQ];
  logic [3:0]         req_width_i [NUM_REQ];
  logic [DATA_W-1:0]  req_data_i  [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready_o;
  logic [DATA_W-1:0]  req_data_o;
  logic [NUM_REQ-1:0] grant_o;

  logic               mem_ce_o;
  logic               mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [3:0]         mem_width_o;
  logic [DATA_W-1:0]  mem_data_o;
  logic [DATA_W-1:0]  mem_data_i;
  logic               mem_ready_i;

  modport master (
    input  req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i,
    input  mem_data_i, mem_ready_i,
    output req_ready_o, req_data_o, grant_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
  );

  modport slave (
    output req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i,
    output mem_data_i, mem_ready_i,
    input  req_ready_o, req_data_o, grant_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next requester after 'last', as index and one-hot.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [MAX_REQ-1:0]   req_pad;
  logic [IDX_MAX_W-1:0] pick;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    pick                   = next_grant(req_pad, IDX_MAX_W'(last), NUM_REQ);
    valid                  = |req;
    idx                    = IDX_W'(pick);
    onehot                 = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, non-preemptive arbiter serializing NUM_REQ request bundles onto one memory port.
// Define MEM_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYC cycles and expose sticky timeout_o.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          timeout_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   gnt_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_cnt;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req_ce_i),
    .last   (last_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Grant/issue/complete sequencing; the memory bundle is frozen from grant until the next idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      last_q          <= IDX_W'(NUM_REQ - 1);
      gnt_idx         <= '0;
      bus.grant_o     <= '0;
      bus.req_ready_o <= '0;
      bus.req_data_o  <= '0;
      bus.mem_ce_o    <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_width_o <= '0;
      bus.mem_data_o  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt         <= '0;
      timeout_o       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt_idx         <= pick_idx;
            bus.grant_o     <= pick_onehot;
            bus.mem_ce_o    <= 1'b1;
            bus.mem_we_o    <= bus.req_we_i[pick_idx];
            bus.mem_addr_o  <= ADDR_W'(bus.req_addr_i[pick_idx]);
            bus.mem_width_o <= bus.req_width_i[pick_idx];
            bus.mem_data_o  <= DATA_W'(bus.req_data_i[pick_idx]);
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
            state           <= S_ISSUE;
          end
        end

        // A ready already present in the issue cycle completes just like one in the wait state.
        S_ISSUE, S_WAIT: begin
          if (bus.mem_ready_i) begin
            bus.mem_ce_o    <= 1'b0;
            bus.req_data_o  <= DATA_W'(bus.mem_data_i);
            bus.req_ready_o <= bus.grant_o;
            last_q          <= gnt_idx;
            state           <= S_DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus.mem_ce_o    <= 1'b0;
            bus.req_data_o  <= '0;
            bus.req_ready_o <= bus.grant_o;
            last_q          <= gnt_idx;
            timeout_o       <= 1'b1;
            state           <= S_DONE;
          end
`endif
          else begin
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt         <= tmo_cnt + TMO_W'(1);
`endif
            state           <= S_WAIT;
          end
        end

        S_DONE: begin
          bus.req_ready_o <= '0;
          bus.grant_o     <= '0;
          state           <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_o;
`endif

  mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Stimulus controls shared by the directed and random phases.
  bit             rand_en  = 1'b0;
  bit             spur_en  = 1'b0;
  bit             rearm_en = 1'b0;
  bit             mem_hang = 1'b0;
  int             mem_delay = 0;
  logic [DW-1:0]  mem_rdata = '0;
  logic [N-1:0]   rearm_pending = '0;

  // Memory responder: ready after mem_delay cycles of ce, optional stray ready while ce is low.
  initial begin : memory
    int  cnt;
    bit  served;
    cnt = 0;
    served = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.mem_ready_i = 1'b0;
        cnt = 0;
        served = 1'b0;
      end else if (bus.mem_ce_o && !served) begin
        if (!mem_hang && cnt >= mem_delay) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_data_i  = rand_en ? DW'($urandom) : mem_rdata;
          served = 1'b1;
        end else begin
          bus.mem_ready_i = 1'b0;
          cnt++;
        end
      end else if (bus.mem_ce_o) begin
        bus.mem_ready_i = 1'b0;
      end else begin
        served = 1'b0;
        cnt = 0;
        bus.mem_ready_i = spur_en && ($urandom_range(0, 7) == 0);
        bus.mem_data_i  = DW'($urandom);
        if (rand_en) mem_delay = int'($urandom_range(0, 4));
      end
    end
  end

  // Requesters: drop ce on their ready pulse, optionally re-request or churn inputs.
  initial begin : requesters
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready_o[i]) begin
          bus.req_ce_i[i]  = 1'b0;
          rearm_pending[i] = rearm_en;
        end else if (rearm_pending[i]) begin
          bus.req_ce_i[i]  = 1'b1;
          rearm_pending[i] = 1'b0;
        end else if (rand_en) begin
          if (!bus.req_ce_i[i] && $urandom_range(0, 3) == 0) begin
            bus.req_ce_i[i]    = 1'b1;
            bus.req_we_i[i]    = 1'($urandom);
            bus.req_addr_i[i]  = AW'($urandom);
            bus.req_width_i[i] = 4'($urandom);
            bus.req_data_i[i]  = DW'($urandom);
          end else if (bus.req_ce_i[i] && $urandom_range(0, 7) == 0) begin
            bus.req_addr_i[i]  = AW'($urandom);
            bus.req_data_i[i]  = DW'($urandom);
          end else if (bus.req_ce_i[i] && bus.grant_o[i] && $urandom_range(0, 15) == 0) begin
            bus.req_ce_i[i]    = 1'b0;
          end
        end
      end
    end
  end

  // Transaction-level reference: who is being served, with what bundle, and what completed last.
  bit            m_busy, m_cool, m_tmo;
  int            m_win, m_last, m_busy_cyc;
  logic [N-1:0]  m_ready;
  logic [DW-1:0] m_rdata, m_wdata;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_width;

  function automatic int rr_ref(input logic [N-1:0] ce, input int last);
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = ce >> ((last + k) % N);
      if (sh[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_cool = 1'b0; m_tmo = 1'b0;
    m_win = 0; m_last = N - 1; m_busy_cyc = 0;
    m_ready = '0; m_rdata = '0;
  endtask

  task automatic model_complete(input logic [DW-1:0] d);
    m_busy  = 1'b0;
    m_cool  = 1'b1;
    m_last  = m_win;
    m_rdata = d;
    m_ready = '0;
    m_ready[m_win] = 1'b1;
  endtask

  initial begin : model
    int w;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_ready = '0;
        if (m_cool) begin
          m_cool = 1'b0;
        end else if (m_busy) begin
          m_busy_cyc++;
          if (bus.mem_ready_i) model_complete(bus.mem_data_i);
`ifdef MEM_ARB_TIMEOUT_EN
          else if (m_busy_cyc == int'(TIMEOUT_CYC)) begin
            model_complete('0);
            m_tmo = 1'b1;
          end
`endif
        end else begin
          w = rr_ref(bus.req_ce_i, m_last);
          if (w >= 0) begin
            m_busy     = 1'b1;
            m_win      = w;
            m_busy_cyc = 0;
            m_we       = bus.req_we_i[w];
            m_addr     = bus.req_addr_i[w];
            m_width    = bus.req_width_i[w];
            m_wdata    = bus.req_data_i[w];
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  initial begin : compare
    logic [N-1:0] eg;
    forever begin
      @(negedge clk);
      if (!rst) begin
        eg = '0;
        if (m_busy || m_cool) eg[m_win] = 1'b1;
        chk("grant", bus.grant_o, eg);
        chk("mem_ce", bus.mem_ce_o, m_busy);
        chk("ready", bus.req_ready_o, m_ready);
        chk("rdata", bus.req_data_o, m_rdata);
        if (m_busy) begin
          chk("mem_we", bus.mem_we_o, m_we);
          chk("mem_addr", bus.mem_addr_o, m_addr);
          chk("mem_width", bus.mem_width_o, m_width);
          chk("mem_wdata", bus.mem_data_o, m_wdata);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("timeout", timeout_o, m_tmo);
`endif
      end
    end
  end

  task automatic wait_new_grant(output logic [N-1:0] g, output logic [AW-1:0] a);
    int t;
    t = 0;
    while (bus.grant_o != '0 && t < 50) begin step(); t++; end
    while (bus.grant_o == '0 && t < 50) begin step(); t++; end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_wait: actual=no grant within 50 cycles required=a new grant at %0t", $time);
    end
    g = bus.grant_o;
    a = bus.mem_addr_o;
  endtask

  task automatic reset_dut();
    bus.req_ce_i  = '0;
    rearm_pending = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin : main
    logic [N-1:0]  g, e, rdy_seen;
    logic [AW-1:0] a;
    int            rdy_cnt, t;

    rst = 1'b1;
    bus.req_ce_i = '0;
    bus.req_we_i = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr_i[i]  = '0;
      bus.req_width_i[i] = '0;
      bus.req_data_i[i]  = '0;
    end
    step(2);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_mem_ce", bus.mem_ce_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_rdata", bus.req_data_o, 0);
    rst = 1'b0;
    step();

    // Single requester read with a slow memory.
    bus.req_addr_i[2]  = 32'h100;
    bus.req_we_i[2]    = 1'b0;
    bus.req_width_i[2] = 4'hF;
    mem_delay = 2;
    mem_rdata = 32'hDEADBEEF;
    bus.req_ce_i = 4'b0100;
    step();
    chk("t1_mem_ce", bus.mem_ce_o, 1);
    chk("t1_addr", bus.mem_addr_o, 32'h100);
    chk("t1_grant", bus.grant_o, 4'b0100);
    rdy_cnt = 0;
    rdy_seen = '0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready_o != '0) begin
        rdy_cnt++;
        rdy_seen = bus.req_ready_o;
      end
      step();
    end
    chk("t1_ready_cycles", rdy_cnt, 1);
    chk("t1_ready_vec", rdy_seen, 4'b0100);
    chk("t1_rdata", bus.req_data_o, 32'hDEADBEEF);

    // All four continuously requesting, zero-wait memory.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      bus.req_addr_i[i]  = AW'(32'h1000 + 16 * i);
      bus.req_we_i[i]    = 1'b0;
      bus.req_width_i[i] = 4'hF;
    end
    mem_delay = 0;
    rearm_en = 1'b1;
    bus.req_ce_i = '1;
    for (int k = 0; k < 5; k++) begin
      wait_new_grant(g, a);
      e = '0;
      e[k % N] = 1'b1;
      chk("t2_grant", g, e);
      chk("t2_addr", a, AW'(32'h1000 + 16 * (k % N)));
    end
    rearm_en = 1'b0;

    // Write from requester 1 while requester 3 retargets its address mid-grant.
    reset_dut();
    bus.req_we_i[1]    = 1'b1;
    bus.req_addr_i[1]  = 32'h200;
    bus.req_width_i[1] = 4'hF;
    bus.req_data_i[1]  = 32'h12345678;
    bus.req_we_i[3]    = 1'b0;
    bus.req_addr_i[3]  = 32'h300;
    bus.req_width_i[3] = 4'h3;
    mem_delay = 3;
    bus.req_ce_i = 4'b1010;
    wait_new_grant(g, a);
    chk("t3_grant", g, 4'b0010);
    chk("t3_we", bus.mem_we_o, 1);
    chk("t3_width", bus.mem_width_o, 4'hF);
    bus.req_addr_i[3] = 32'h3C0;
    bus.req_data_i[1] = 32'hFFFF0000;
    for (int k = 0; k < 20 && bus.mem_ce_o; k++) begin
      chk("t3_wdata_stable", bus.mem_data_o, 32'h12345678);
      step();
    end
    wait_new_grant(g, a);
    chk("t3_next_grant", g, 4'b1000);
    chk("t3_next_addr", a, 32'h3C0);
    step(6);

    // Wrap-around after requester 3 was served last.
    mem_delay = 1;
    bus.req_ce_i = 4'b1001;
    wait_new_grant(g, a);
    chk("t4_first", g, 4'b0001);
    wait_new_grant(g, a);
    chk("t4_second", g, 4'b1000);
    step(6);

    // Asynchronous reset while waiting on memory.
    mem_delay = 10;
    bus.req_ce_i = 4'b0010;
    wait_new_grant(g, a);
    step(2);
    rst = 1'b1;
    #1;
    chk("t5_mem_ce", bus.mem_ce_o, 0);
    chk("t5_grant", bus.grant_o, 0);
    chk("t5_ready", bus.req_ready_o, 0);
    step();
    rst = 1'b0;
    mem_delay = 0;
    bus.req_ce_i = '1;
    wait_new_grant(g, a);
    chk("t5_first_after_rst", g, 4'b0001);
    step(30);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: forced completion after the timeout.
    reset_dut();
    mem_hang = 1'b1;
    bus.req_ce_i = 4'b0001;
    wait_new_grant(g, a);
    t = 0;
    while (bus.req_ready_o == '0 && t < 1100) begin step(); t++; end
    chk("tmo_latency", t, 1024);
    chk("tmo_ready", bus.req_ready_o, 4'b0001);
    chk("tmo_rdata", bus.req_data_o, 0);
    chk("tmo_flag", timeout_o, 1);
    mem_hang = 1'b0;
    step(2);
    bus.req_ce_i[1] = 1'b1;
    wait_new_grant(g, a);
    chk("tmo_next_grant", g, 4'b0010);
    step(10);
`endif

    // Randomized traffic with stray memory ready pulses.
    reset_dut();
    rand_en = 1'b1;
    spur_en = 1'b1;
    step(3000);
    rand_en = 1'b0;
    spur_en = 1'b0;
    bus.req_ce_i = '0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
